// File: rtl/serial_pkg.sv
// Shared definitions for the single-wire serial link (encoder and decoder).
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } serial_state_t;

  localparam logic SERIAL_IDLE_LEVEL  = 1'b0;
  localparam logic SERIAL_START_LEVEL = 1'b1;
  localparam logic SERIAL_STOP_LEVEL  = 1'b0;

endpackage

// File: rtl/serial_bit_timer.sv
// Bit timer: strobes bitEnd on the last cycle of each BIT_CYCLES-long bit.
module serial_bit_timer #(
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic clock,
  input  logic resetN,
  input  logic restart,
  output logic bitEnd
);

  localparam int unsigned CntW = $clog2(BIT_CYCLES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(BIT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    bitEnd = (cnt_q == LastCnt);
    cnt_d  = (restart || bitEnd) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_encoder.sv
// Parallel-to-serial frame encoder: start, data MSB-first, optional parity, stop.
// Define SERIAL_ENCODER_PARITY_EN to insert an even-parity bit after the data.
module serial_encoder
  import serial_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic [DATA_WIDTH-1:0] parallelIn,
  input  logic                  loadValid,
  output logic                  loadReady,
  output logic                  serialOut,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_WIDTH - 1);

  serial_state_t         state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  serial_q, serial_d;
  logic                  done_q, done_d;
`ifdef SERIAL_ENCODER_PARITY_EN
  logic                  parity_q, parity_d;
`endif
  logic                  bit_end;
  logic                  load;

  // Timer is held at zero while idle so every frame starts on a fresh bit.
  serial_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clock  (clock),
    .resetN (resetN),
    .restart(state_q == IDLE),
    .bitEnd (bit_end)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      serial_q <= SERIAL_IDLE_LEVEL;
      done_q   <= 1'b0;
`ifdef SERIAL_ENCODER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      serial_q <= serial_d;
      done_q   <= done_d;
`ifdef SERIAL_ENCODER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    load    = (state_q == IDLE) && loadValid;
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
`ifdef SERIAL_ENCODER_PARITY_EN
    parity_d = load ? ^parallelIn : parity_q;
`endif
    unique case (state_q)
      IDLE:   if (loadValid) state_d = START;
      START:  if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end && (idx_q == '0)) begin
`ifdef SERIAL_ENCODER_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP:   if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d = parallelIn;
      idx_d   = LastIdx;
    end else if ((state_q == DATA) && bit_end) begin
      shift_d = shift_q << 1;
      idx_d   = idx_q - 1'b1;
    end
  end

  // The line register follows the state being entered, so the start bit
  // appears on the handshake edge itself.
  always_comb begin
    unique case (state_d)
      IDLE:   serial_d = SERIAL_IDLE_LEVEL;
      START:  serial_d = SERIAL_START_LEVEL;
      DATA:   serial_d = shift_d[DATA_WIDTH-1];
`ifdef SERIAL_ENCODER_PARITY_EN
      PARITY: serial_d = parity_d;
`else
      PARITY: serial_d = SERIAL_IDLE_LEVEL;
`endif
      STOP:   serial_d = SERIAL_STOP_LEVEL;
      default: serial_d = SERIAL_IDLE_LEVEL;
    endcase
    done_d    = (state_q == STOP) && bit_end;
    loadReady = (state_q == IDLE);
    busy      = (state_q != IDLE);
    serialOut = serial_q;
    done      = done_q;
  end

endmodule

// File: tb/tb_serial_encoder.sv
// Bench for serial_encoder: a BIT_CYCLES=1 and a BIT_CYCLES=3 instance against a frame model.
module tb_serial_encoder;

`ifdef SERIAL_ENCODER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clock = 1'b0;
  logic       resetN;
  logic       lv   [2];
  logic [7:0] pin  [2];
  logic       so   [2];
  logic       rdy  [2];
  logic       bsy  [2];
  logic       dn   [2];

  int errors = 0;
  int checks = 0;

  // Sample vectors packed as {serialOut, done, busy, loadReady}.
  logic [3:0] exp_v [0:255];
  logic [3:0] obs_v [0:255];
  int         exp_len;

  always #5 clock = ~clock;

  serial_encoder #(
    .DATA_WIDTH(8),
    .BIT_CYCLES(1)
  ) u_dut_fast (
    .clock     (clock),
    .resetN    (resetN),
    .parallelIn(pin[0]),
    .loadValid (lv[0]),
    .loadReady (rdy[0]),
    .serialOut (so[0]),
    .busy      (bsy[0]),
    .done      (dn[0])
  );

  serial_encoder #(
    .DATA_WIDTH(8),
    .BIT_CYCLES(3)
  ) u_dut_slow (
    .clock     (clock),
    .resetN    (resetN),
    .parallelIn(pin[1]),
    .loadValid (lv[1]),
    .loadReady (rdy[1]),
    .serialOut (so[1]),
    .busy      (bsy[1]),
    .done      (dn[1])
  );

  function automatic int bc_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Expected samples from the edge after the handshake: frame bits, done cycle, idle.
  task automatic build_expected(input logic [7:0] w, input int bc);
    logic bits[$];
    bits.push_back(1'b1);
    for (int i = 7; i >= 0; i--) bits.push_back(w[i]);
    if (P == 1) bits.push_back(^w);
    bits.push_back(1'b0);
    exp_len = 0;
    foreach (bits[b]) begin
      for (int r = 0; r < bc; r++) begin
        exp_v[exp_len] = {bits[b], 1'b0, 1'b1, 1'b0};
        exp_len++;
      end
    end
    exp_v[exp_len] = 4'b0101;
    exp_len++;
    exp_v[exp_len] = 4'b0001;
    exp_len++;
  endtask

  task automatic capture(input int d, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      obs_v[k] = {so[d], dn[d], bsy[d], rdy[d]};
    end
  endtask

  // Returns #1 after the handshake edge with loadValid dropped and parallelIn scrambled.
  task automatic load(input int d, input logic [7:0] w);
    int waited;
    waited = 0;
    @(posedge clock);
    #1;
    pin[d] = w;
    lv[d]  = 1'b1;
    @(negedge clock);
    while (!rdy[d] && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    checks++;
    if (rdy[d] !== 1'b1) begin
      errors++;
      $display("FAIL load_ready d=%0d got=%b want=1", d, rdy[d]);
    end
    @(posedge clock);
    #1;
    lv[d]  = 1'b0;
    pin[d] = 8'($urandom);
  endtask

  task automatic test_reset();
    resetN = 1'b1;
    #1;
    resetN = 1'b0;
    for (int d = 0; d < 2; d++) begin
      lv[d]  = 1'b1;
      pin[d] = 8'hA5;
    end
    repeat (4) begin
      @(negedge clock);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({so[d], dn[d], bsy[d], rdy[d]} !== 4'b0001) begin
          errors++;
          $display("FAIL reset_hold d=%0d got=%b want=0001", d, {so[d], dn[d], bsy[d], rdy[d]});
        end
      end
    end
    @(posedge clock);
    #1;
    lv[0]  = 1'b0;
    lv[1]  = 1'b0;
    resetN = 1'b1;
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({so[d], dn[d], bsy[d], rdy[d]} !== 4'b0001) begin
        errors++;
        $display("FAIL reset_release d=%0d got=%b want=0001", d, {so[d], dn[d], bsy[d], rdy[d]});
      end
    end
  endtask

  task automatic test_frames(input int d);
    logic [7:0] words [6];
    words = '{8'hA5, 8'h07, 8'h80, 8'h3C, 8'($urandom), 8'($urandom)};
    foreach (words[i]) begin
      build_expected(words[i], bc_of(d));
      load(d, words[i]);
      capture(d, exp_len);
      for (int k = 0; k < exp_len; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL frame d=%0d w=%h k=%0d got=%b want=%b", d, words[i], k, obs_v[k],
                   exp_v[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int f;
    f = 10 + P;
    @(posedge clock);
    #1;
    pin[0] = 8'h01;
    lv[0]  = 1'b1;
    @(posedge clock);
    #1;
    pin[0] = 8'hFF;
    build_expected(8'h01, 1);
    capture(0, f + 1);
    for (int k = 0; k <= f; k++) begin
      checks++;
      if (obs_v[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL b2b_first k=%0d got=%b want=%b", k, obs_v[k], exp_v[k]);
      end
    end
    @(posedge clock);
    #1;
    lv[0]  = 1'b0;
    pin[0] = 8'($urandom);
    build_expected(8'hFF, 1);
    capture(0, exp_len);
    for (int k = 0; k < exp_len; k++) begin
      checks++;
      if (obs_v[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL b2b_second k=%0d got=%b want=%b", k, obs_v[k], exp_v[k]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    load(0, 8'hFF);
    repeat (4) @(posedge clock);
    #2;
    checks++;
    if ({so[0], bsy[0]} !== 2'b11) begin
      errors++;
      $display("FAIL midframe_active got=%b want=11", {so[0], bsy[0]});
    end
    resetN = 1'b0;
    #1;
    checks++;
    if ({so[0], dn[0], bsy[0], rdy[0]} !== 4'b0001) begin
      errors++;
      $display("FAIL midframe_abort got=%b want=0001", {so[0], dn[0], bsy[0], rdy[0]});
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetN = 1'b1;
    capture(0, 4);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_v[k] !== 4'b0001) begin
        errors++;
        $display("FAIL midframe_quiet k=%0d got=%b want=0001", k, obs_v[k]);
      end
    end
    build_expected(8'h3C, 1);
    load(0, 8'h3C);
    capture(0, exp_len);
    for (int k = 0; k < exp_len; k++) begin
      checks++;
      if (obs_v[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL after_reset k=%0d got=%b want=%b", k, obs_v[k], exp_v[k]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    lv[0]  = 1'b0;
    lv[1]  = 1'b0;
    pin[0] = 8'h00;
    pin[1] = 8'h00;
    test_reset();
    test_frames(0);
    test_frames(1);
    test_back_to_back();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
